// File: rtl/l2tlb_ctx.sv
// l2tlb_ctx: fully associative L2 TLB with an SPBTR context table and per-context flash invalidate
module l2tlb_ctx #(
    parameter int ENTRIES = 16,
    parameter int NCTX = 4,
    parameter int VPN_W = 36,
    parameter int PPN_W = 28,
    parameter int SPBTR_W = 50,
    parameter int ID_W = 5,
    localparam int CTX_W = $clog2(NCTX),
    localparam int E_W = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lkp_valid,
    output logic               lkp_retry,
    input  logic [VPN_W-1:0]   lkp_vpn,
    input  logic [SPBTR_W-1:0] lkp_spbtr,
    input  logic [ID_W-1:0]    lkp_id,
    output logic               rsp_valid,
    input  logic               rsp_retry,
    output logic               rsp_hit,
    output logic [PPN_W-1:0]   rsp_ppn,
    output logic [ID_W-1:0]    rsp_id,
    output logic               miss_valid,
    input  logic               miss_retry,
    output logic [VPN_W-1:0]   miss_vpn,
    output logic [CTX_W-1:0]   miss_ctx,
    output logic [ID_W-1:0]    miss_id,
    input  logic               fill_valid,
    input  logic [VPN_W-1:0]   fill_vpn,
    input  logic [PPN_W-1:0]   fill_ppn,
    input  logic [CTX_W-1:0]   fill_ctx,
    output logic               inv_valid,
    output logic [CTX_W-1:0]   inv_ctx
);
    logic [ENTRIES-1:0] e_valid;
    logic [VPN_W-1:0]   e_vpn [ENTRIES];
    logic [PPN_W-1:0]   e_ppn [ENTRIES];
    logic [CTX_W-1:0]   e_ctx [ENTRIES];
    logic [NCTX-1:0]    c_valid;
    logic [SPBTR_W-1:0] c_spbtr [NCTX];
    logic [CTX_W-1:0]   c_ptr;
    logic [E_W-1:0]     r_ptr;
    logic               accept, alloc, c_hit, c_free_ok, l_hit, f_hit, f_free_ok, f_ok;
    logic [CTX_W-1:0]   c_match, c_free, slot;
    logic [PPN_W-1:0]   l_ppn;
    logic [E_W-1:0]     f_idx, f_free, f_way;

    assign lkp_retry = (rsp_valid && rsp_retry) || (miss_valid && miss_retry);
    assign accept = lkp_valid && !lkp_retry;
    assign alloc = accept && !c_hit;

    // Context match/allocation, entry lookup and fill placement, all against the pre-update arrays
    always_comb begin
        c_hit = 1'b0;
        c_match = '0;
        c_free_ok = 1'b0;
        c_free = '0;
        for (int i = NCTX - 1; i >= 0; i--) begin
            if (c_valid[i] && c_spbtr[i] == lkp_spbtr) begin
                c_hit = 1'b1;
                c_match = CTX_W'(i);
            end
            if (!c_valid[i]) begin
                c_free_ok = 1'b1;
                c_free = CTX_W'(i);
            end
        end
        slot = c_hit ? c_match : (c_free_ok ? c_free : c_ptr);
        l_hit = 1'b0;
        l_ppn = '0;
        f_hit = 1'b0;
        f_idx = '0;
        f_free_ok = 1'b0;
        f_free = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (c_hit && e_valid[i] && e_vpn[i] == lkp_vpn && e_ctx[i] == slot) begin
                l_hit = 1'b1;
                l_ppn = e_ppn[i];
            end
            if (e_valid[i] && e_vpn[i] == fill_vpn && e_ctx[i] == fill_ctx) begin
                f_hit = 1'b1;
                f_idx = E_W'(i);
            end
            if (!e_valid[i]) begin
                f_free_ok = 1'b1;
                f_free = E_W'(i);
            end
        end
        f_way = f_hit ? f_idx : (f_free_ok ? f_free : r_ptr);
        f_ok = fill_valid && c_valid[fill_ctx] && !(alloc && slot == fill_ctx);
    end

    // Valid bits, pointers and registered responses; a flush is applied before the fill so the fill wins its own entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_valid <= '0;
            c_valid <= '0;
            c_ptr <= '0;
            r_ptr <= '0;
            rsp_valid <= 1'b0;
            rsp_hit <= 1'b0;
            rsp_ppn <= '0;
            rsp_id <= '0;
            miss_valid <= 1'b0;
            miss_vpn <= '0;
            miss_ctx <= '0;
            miss_id <= '0;
            inv_valid <= 1'b0;
            inv_ctx <= '0;
        end else begin
            if (alloc) begin
                c_valid[slot] <= 1'b1;
                if (!c_free_ok) c_ptr <= c_ptr + 1'b1;
                inv_ctx <= slot;
                for (int i = 0; i < ENTRIES; i++)
                    if (e_ctx[i] == slot) e_valid[i] <= 1'b0;
            end
            if (f_ok) begin
                e_valid[f_way] <= 1'b1;
                if (!f_hit && !f_free_ok) r_ptr <= r_ptr + 1'b1;
            end
            inv_valid <= alloc;
            rsp_valid <= accept || (rsp_valid && rsp_retry);
            miss_valid <= accept ? !l_hit : (miss_valid && miss_retry);
            if (accept) begin
                rsp_hit <= l_hit;
                rsp_ppn <= l_ppn;
                rsp_id <= lkp_id;
                miss_vpn <= lkp_vpn;
                miss_ctx <= slot;
                miss_id <= lkp_id;
            end
        end
    end

    // Array payloads need no reset; they are only observed behind a valid bit
    always_ff @(posedge clk) begin
        if (alloc) c_spbtr[slot] <= lkp_spbtr;
        if (f_ok) begin
            e_vpn[f_way] <= fill_vpn;
            e_ppn[f_way] <= fill_ppn;
            e_ctx[f_way] <= fill_ctx;
        end
    end
endmodule

// File: tb/tb_l2tlb_ctx.sv
// tb_l2tlb_ctx: directed and random checks of l2tlb_ctx against a behavioural TLB model
module tb_l2tlb_ctx;
    localparam int ENTRIES = 16, NCTX = 4, VPN_W = 36, PPN_W = 28, SPBTR_W = 50, ID_W = 5, CTX_W = 2;

    logic clk = 1'b0, reset = 1'b0;
    logic lkp_valid = 1'b0, lkp_retry, rsp_valid, rsp_retry = 1'b0, rsp_hit;
    logic miss_valid, miss_retry = 1'b0, fill_valid = 1'b0, inv_valid;
    logic [VPN_W-1:0] lkp_vpn = '0, miss_vpn, fill_vpn = '0;
    logic [SPBTR_W-1:0] lkp_spbtr = '0;
    logic [ID_W-1:0] lkp_id = '0, rsp_id, miss_id;
    logic [PPN_W-1:0] rsp_ppn, fill_ppn = '0;
    logic [CTX_W-1:0] miss_ctx, fill_ctx = '0, inv_ctx;

    always #5 clk = ~clk;

    l2tlb_ctx dut (
        .clk(clk), .reset(reset),
        .lkp_valid(lkp_valid), .lkp_retry(lkp_retry), .lkp_vpn(lkp_vpn), .lkp_spbtr(lkp_spbtr), .lkp_id(lkp_id),
        .rsp_valid(rsp_valid), .rsp_retry(rsp_retry), .rsp_hit(rsp_hit), .rsp_ppn(rsp_ppn), .rsp_id(rsp_id),
        .miss_valid(miss_valid), .miss_retry(miss_retry), .miss_vpn(miss_vpn), .miss_ctx(miss_ctx), .miss_id(miss_id),
        .fill_valid(fill_valid), .fill_vpn(fill_vpn), .fill_ppn(fill_ppn), .fill_ctx(fill_ctx),
        .inv_valid(inv_valid), .inv_ctx(inv_ctx)
    );

    int total = 0, bad = 0;

    bit m_ev [ENTRIES];
    logic [VPN_W-1:0] m_vpn [ENTRIES];
    logic [PPN_W-1:0] m_ppn [ENTRIES];
    int m_ctx [ENTRIES];
    bit m_cv [NCTX];
    logic [SPBTR_W-1:0] m_sp [NCTX];
    int m_cp, m_rp;

    bit x_rv, x_hit, x_mv, x_iv;
    logic [PPN_W-1:0] x_ppn;
    logic [ID_W-1:0] x_rid, x_mid;
    logic [VPN_W-1:0] x_mvpn;
    int x_mctx, x_ictx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < ENTRIES; e++) m_ev[e] = 1'b0;
        for (int c = 0; c < NCTX; c++) m_cv[c] = 1'b0;
        m_cp = 0;
        m_rp = 0;
        x_rv = 0;
        x_mv = 0;
        x_iv = 0;
    endtask

    // One clock of the TLB's rules, evaluated from the inputs presented before the edge
    task automatic model_step();
        bit acc, alloc, l_hit, f_ok;
        int s, fw;
        logic [PPN_W-1:0] l_ppn;
        acc = lkp_valid && !((x_rv && rsp_retry) || (x_mv && miss_retry));
        s = -1;
        for (int c = 0; c < NCTX; c++)
            if (m_cv[c] && m_sp[c] == lkp_spbtr) s = c;
        alloc = acc && s < 0;
        l_hit = 0;
        l_ppn = '0;
        if (s >= 0)
            for (int e = 0; e < ENTRIES; e++)
                if (m_ev[e] && m_vpn[e] == lkp_vpn && m_ctx[e] == s) begin
                    l_hit = 1;
                    l_ppn = m_ppn[e];
                end
        if (alloc) begin
            for (int c = NCTX - 1; c >= 0; c--)
                if (!m_cv[c]) s = c;
            if (s < 0) begin
                s = m_cp;
                m_cp = (m_cp + 1) % NCTX;
            end
        end
        f_ok = fill_valid && m_cv[fill_ctx] && !(alloc && s == int'(fill_ctx));
        fw = -1;
        if (f_ok) begin
            for (int e = 0; e < ENTRIES; e++)
                if (m_ev[e] && m_vpn[e] == fill_vpn && m_ctx[e] == int'(fill_ctx)) fw = e;
            if (fw < 0)
                for (int e = ENTRIES - 1; e >= 0; e--)
                    if (!m_ev[e]) fw = e;
            if (fw < 0) begin
                fw = m_rp;
                m_rp = (m_rp + 1) % ENTRIES;
            end
        end
        if (alloc) begin
            m_cv[s] = 1;
            m_sp[s] = lkp_spbtr;
            for (int e = 0; e < ENTRIES; e++)
                if (m_ctx[e] == s) m_ev[e] = 0;
        end
        if (f_ok) begin
            m_ev[fw] = 1;
            m_vpn[fw] = fill_vpn;
            m_ppn[fw] = fill_ppn;
            m_ctx[fw] = int'(fill_ctx);
        end
        if (acc) begin
            x_rv = 1;
            x_hit = l_hit;
            x_ppn = l_ppn;
            x_rid = lkp_id;
            x_mv = !l_hit;
            x_mvpn = lkp_vpn;
            x_mctx = s;
            x_mid = lkp_id;
        end else begin
            if (!rsp_retry) x_rv = 0;
            if (!miss_retry) x_mv = 0;
        end
        x_iv = alloc;
        if (alloc) x_ictx = s;
    endtask

    task automatic check_outputs();
        chk("rsp_valid", 64'(rsp_valid), 64'(x_rv));
        if (x_rv) begin
            chk("rsp_hit", 64'(rsp_hit), 64'(x_hit));
            chk("rsp_ppn", 64'(rsp_ppn), 64'(x_ppn));
            chk("rsp_id", 64'(rsp_id), 64'(x_rid));
        end
        chk("miss_valid", 64'(miss_valid), 64'(x_mv));
        if (x_mv) begin
            chk("miss_vpn", 64'(miss_vpn), 64'(x_mvpn));
            chk("miss_ctx", 64'(miss_ctx), 64'(x_mctx));
            chk("miss_id", 64'(miss_id), 64'(x_mid));
        end
        chk("inv_valid", 64'(inv_valid), 64'(x_iv));
        if (x_iv) chk("inv_ctx", 64'(inv_ctx), 64'(x_ictx));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_lkp_retry"}, 64'(lkp_retry), 64'(0));
        chk({tag, "_rsp"}, 64'({rsp_valid, rsp_hit, rsp_ppn, rsp_id}), 64'(0));
        chk({tag, "_miss"}, 64'({miss_valid, miss_vpn, miss_ctx, miss_id}), 64'(0));
        chk({tag, "_inv"}, 64'({inv_valid, inv_ctx}), 64'(0));
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("lkp_retry", 64'(lkp_retry), 64'((x_rv && rsp_retry) || (x_mv && miss_retry)));
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        lkp_valid = 0;
        fill_valid = 0;
        rsp_retry = 0;
        miss_retry = 0;
    endtask

    task automatic lookup(input logic [VPN_W-1:0] v, input logic [SPBTR_W-1:0] sp, input logic [ID_W-1:0] id);
        lkp_valid = 1;
        lkp_vpn = v;
        lkp_spbtr = sp;
        lkp_id = id;
    endtask

    task automatic fill(input logic [VPN_W-1:0] v, input logic [PPN_W-1:0] p, input logic [CTX_W-1:0] c);
        fill_valid = 1;
        fill_vpn = v;
        fill_ppn = p;
        fill_ctx = c;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
        // first lookup allocates slot 0 and misses
        idle();
        lookup(36'h100, 50'hA, 5'd3);
        cycle();
        chk("t1_hit", 64'(rsp_hit), 64'(0));
        chk("t1_id", 64'(rsp_id), 64'(3));
        chk("t1_miss", 64'({miss_valid, miss_ctx}), 64'(3'b100));
        chk("t1_inv", 64'({inv_valid, inv_ctx}), 64'(3'b100));
        // fill then hit
        idle();
        fill(36'h100, 28'h55, 2'd0);
        cycle();
        idle();
        lookup(36'h100, 50'hA, 5'd4);
        cycle();
        chk("t2_hit", 64'({rsp_hit, rsp_ppn}), 64'({1'b1, 28'h55}));
        chk("t2_noinv", 64'({miss_valid, inv_valid}), 64'(0));
        // five contexts: the fifth reuses slot 0
        idle();
        lookup(36'h100, 50'hB, 5'd5);
        cycle();
        lookup(36'h100, 50'hC, 5'd6);
        cycle();
        lookup(36'h100, 50'hD, 5'd7);
        cycle();
        lookup(36'h100, 50'hE, 5'd8);
        cycle();
        chk("t3_inv", 64'({inv_valid, inv_ctx}), 64'(3'b100));
        lookup(36'h100, 50'hA, 5'd9);
        cycle();
        chk("t3_evicted", 64'(rsp_hit), 64'(0));
        // 17 fills into context slot 1: the 17th replaces entry 0
        idle();
        for (int k = 1; k <= 17; k++) begin
            fill(VPN_W'(36'h1000 + k), PPN_W'(k), 2'd1);
            cycle();
        end
        idle();
        for (int k = 1; k <= 17; k++) begin
            lookup(VPN_W'(36'h1000 + k), 50'hA, ID_W'(k));
            cycle();
            chk("t4_hit", 64'(rsp_hit), 64'(k != 1));
        end
        // response backpressure holds the output and blocks lookups
        idle();
        lookup(36'h1005, 50'hA, 5'd7);
        cycle();
        lookup(36'h1006, 50'hA, 5'd9);
        rsp_retry = 1;
        repeat (3) begin
            cycle();
            chk("t5_stall_id", 64'(rsp_id), 64'(7));
        end
        idle();
        cycle();
        chk("t5_released", 64'({rsp_valid, lkp_retry}), 64'(0));
        // same-cycle fill and lookup: lookup sees the old array
        lookup(36'h200, 50'hA, 5'd1);
        fill(36'h200, 28'h77, 2'd1);
        cycle();
        chk("t6_miss", 64'({rsp_hit, miss_valid}), 64'(2'b01));
        idle();
        lookup(36'h200, 50'hA, 5'd2);
        cycle();
        chk("t6_hit", 64'({rsp_hit, rsp_ppn}), 64'({1'b1, 28'h77}));
        // random traffic with backpressure and context churn
        for (int n = 0; n < 1500; n++) begin
            lkp_valid = $urandom_range(0, 3) != 0;
            lkp_vpn = VPN_W'(32'h300 + $urandom_range(0, 7));
            lkp_spbtr = SPBTR_W'(32'h20 + $urandom_range(0, 5));
            lkp_id = ID_W'($urandom);
            fill_valid = $urandom_range(0, 2) == 0;
            fill_vpn = VPN_W'(32'h300 + $urandom_range(0, 7));
            fill_ppn = PPN_W'($urandom);
            fill_ctx = CTX_W'($urandom_range(0, 3));
            rsp_retry = $urandom_range(0, 3) == 0;
            miss_retry = $urandom_range(0, 3) == 0;
            cycle();
        end
        // reset while a response is pending clears outputs immediately
        idle();
        lookup(36'h300, 50'h99, 5'd11);
        cycle();
        chk("t7_pending", 64'(rsp_valid), 64'(1));
        idle();
        reset = 0;
        #1;
        chk_zero("midreset");
        model_reset();
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
        lookup(36'h300, 50'h99, 5'd12);
        cycle();
        chk("t7_after", 64'({inv_valid, inv_ctx, rsp_hit}), 64'(4'b1000));
        idle();
        cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/l2tlb_ctx.md
Name: l2tlb_ctx

Overview:
- Parametrised L2 TLB for the l2cache. Fully associative translation array plus a small SPBTR context table: NCTX slots map an SPBTR to a context id.
- Accepts lookups, returns hit/miss responses and issues miss requests toward the walker/directory side. Installs fills.
- On context-slot reallocation, flash-invalidates that context's entries and notifies L1.

Parameters:
ENTRIES, 16, number of TLB entries (power of 2, >=2)
NCTX, 4, number of SPBTR context slots (power of 2, >=2)
VPN_W, 36, virtual page number width
PPN_W, 28, physical page number width
SPBTR_W, 50, SPBTR width
ID_W, 5, request tag width
(CTX_W = log2(NCTX))

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
lkp_valid  in  1  lookup request valid
lkp_retry  out  1  lookup backpressure
lkp_vpn  in  VPN_W  lookup VPN
lkp_spbtr  in  SPBTR_W  lookup SPBTR
lkp_id  in  ID_W  lookup tag
rsp_valid  out  1  response valid
rsp_retry  in  1  response backpressure
rsp_hit  out  1  1=hit
rsp_ppn  out  PPN_W  translated PPN (0 on miss)
rsp_id  out  ID_W  echoed tag
miss_valid  out  1  miss request valid
miss_retry  in  1  miss backpressure
miss_vpn  out  VPN_W  missing VPN
miss_ctx  out  CTX_W  context slot of miss
miss_id  out  ID_W  echoed tag
fill_valid  in  1  fill install (no backpressure)
fill_vpn  in  VPN_W  fill VPN
fill_ppn  in  PPN_W  fill PPN
fill_ctx  in  CTX_W  fill context slot
inv_valid  out  1  one-cycle pulse: context slot invalidated
inv_ctx  out  CTX_W  invalidated slot

Behaviour:
- Reset: the interface is one clock and reset, with reset asynchronous and active-low. Reset clears all entry valid bits, all context-slot valid bits, the replacement pointer and the context pointer. Reset drives every output to 0, with lkp_retry=0. Reset asserted mid-operation drops pending rsp/miss without completion.
- Handshake: a transfer occurs when valid && !retry. Held outputs stay stable while retry is high.
- lkp_retry = (rsp_valid && rsp_retry) || (miss_valid && miss_retry), combinational.
- Latency: a lookup accepted in cycle N presents rsp_valid in cycle N+1, registered. Throughput is one lookup per cycle when unblocked.
- Context match: a lookup compares lkp_spbtr against the valid slots.
  - No match: allocate a slot. The slot is the lowest invalid slot, else the context pointer; the pointer then increments mod NCTX.
  - On allocation, store the SPBTR and clear the valid bit of every entry tagged with that slot in cycle N.
  - Assert inv_valid/inv_ctx in cycle N+1. A fresh (previously invalid) slot also pulses inv_valid.
  - The lookup result is a miss.
- Entry hit: an entry hits when valid, vpn==lkp_vpn and ctx==matched slot. At most one entry can hit.
  - Hit: rsp_hit=1, rsp_ppn=entry ppn, no miss request.
  - Miss: rsp_hit=0, rsp_ppn=0, and miss_valid asserts in N+1 alongside rsp_valid.
  - rsp and miss are dequeued independently.
- Fill: installs in the cycle fill_valid=1.
  - A matching (vpn,ctx) entry is overwritten in place, so duplicates never exist.
  - Otherwise the fill goes to the lowest invalid entry, else the replacement pointer; the pointer then increments mod ENTRIES.
  - A fill to an invalid context slot is dropped.
- Simultaneous events:
  - A lookup and a fill in the same cycle: the lookup sees the pre-fill array.
  - A fill targeting a slot being reallocated in the same cycle: the flush wins and the fill is dropped.
  - A fill hitting the entry chosen for replacement is fine, since there is a single write port.
- Wrap-around: both pointers wrap from max to 0.

Test Plan:
- Reset then lookup vpn=0x100, spbtr=0xA, id=3 -> N+1: rsp_valid=1, rsp_hit=0, rsp_id=3; miss_valid=1, miss_ctx=0; inv_valid=1, inv_ctx=0.
- Fill vpn=0x100, ppn=0x55, ctx=0; re-lookup same -> rsp_hit=1, rsp_ppn=0x55, miss_valid=0, inv_valid=0.
- Five distinct SPBTRs with NCTX=4 -> the fifth reuses slot 0. inv_ctx=0 pulses, and a lookup of vpn 0x100 with spbtr 0xA now misses.
- 17 fills with ENTRIES=16 and distinct vpns -> the 17th overwrites entry 0. The first vpn then misses and vpns 2..17 hit.
- Hold rsp_retry=1 across a pending response -> lkp_retry=1 and rsp fields stay stable. Release -> one transfer, then lkp_retry=0.
- Same-cycle fill and lookup of vpn 0x200 -> the lookup misses; the next lookup hits. Reset asserted while rsp_valid=1 -> all outputs 0 immediately.
